// File: rtl/rvfpga_uart_pkg.sv
// rvfpga_uart_pkg: parity-mode constants and receiver FSM state encoding
package rvfpga_uart_pkg;
  localparam int PAR_NONE = 0;
  localparam int PAR_ODD  = 1;
  localparam int PAR_EVEN = 2;
  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_PARITY, S_STOP, S_BREAK} state_t;
endpackage

// File: rtl/rvfpga_sync_fifo.sv
// rvfpga_sync_fifo: single-clock show-ahead FIFO with full, empty and level
module rvfpga_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_wr,
  input  logic [WIDTH-1:0]       i_wdata,
  input  logic                   i_rd,
  output logic [WIDTH-1:0]       o_rdata,
  output logic                   o_full,
  output logic                   o_empty,
  output logic [$clog2(DEPTH):0] o_level
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_LVL = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_level;
  logic w_rd, w_wr;
  assign o_full  = r_level == FULL_LVL;
  assign o_empty = r_level == '0;
  assign o_level = r_level;
  assign o_rdata = r_mem[r_rp];
  assign w_rd = i_rd && !o_empty;
  assign w_wr = i_wr && (!o_full || w_rd);
  // storage array, written only when the push is accepted
  always_ff @(posedge clk) begin
    if (w_wr) r_mem[r_wp] <= i_wdata;
  end
  // pointers and occupancy; a pop on a full FIFO frees room for a same-cycle push
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
      r_level <= '0;
    end else begin
      if (w_wr) r_wp <= r_wp + 1'b1;
      if (w_rd) r_rp <= r_rp + 1'b1;
      r_level <= r_level + (AW+1)'(w_wr) - (AW+1)'(w_rd);
    end
  end
endmodule

// File: rtl/rvfpga_uart_monitor.sv
// rvfpga_uart_monitor: UART receive decoder buffering characters with framing/parity status
module rvfpga_uart_monitor
  import rvfpga_uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int DATA_BITS    = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 16
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        i_rx,
  output logic [DATA_BITS-1:0]        o_data,
  output logic                        o_frame_err,
  output logic                        o_parity_err,
  output logic                        o_valid,
  input  logic                        i_ready,
  output logic                        o_overflow,
  output logic [$clog2(FIFO_DEPTH):0] o_level,
  output logic [15:0]                 o_count
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT/2 - 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_D = 3'(DATA_BITS - 1);
  localparam logic [2:0] LAST_S = 3'(STOP_BITS - 1);
  state_t r_state;
  logic r_s1, r_s2, r_prev;
  logic [CW-1:0] r_cnt;
  logic [2:0] r_bit;
  logic [DATA_BITS-1:0] r_shift;
  logic r_ferr, r_perr, r_push, r_ovf;
  logic [DATA_BITS+1:0] r_pdata;
  logic [15:0] r_count;
  logic w_tick, w_full, w_empty, w_pop;
  logic [DATA_BITS+1:0] w_head;
  assign w_tick = r_cnt == '0;
  assign w_pop = !w_empty && i_ready;
  assign o_valid = !w_empty;
  assign o_data = w_empty ? '0 : w_head[DATA_BITS+1:2];
  assign o_frame_err = !w_empty && w_head[1];
  assign o_parity_err = !w_empty && w_head[0];
  assign o_overflow = r_ovf;
  assign o_count = r_count;
  // synchronizer, bit timing and frame decoding; a completed frame is pushed one edge later
  always_ff @(posedge clk) begin
    if (rst) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_prev <= 1'b1;
      r_state <= S_IDLE;
      r_cnt <= '0;
      r_bit <= '0;
      r_shift <= '0;
      r_ferr <= 1'b0;
      r_perr <= 1'b0;
      r_push <= 1'b0;
      r_pdata <= '0;
    end else begin
      r_s1 <= i_rx;
      r_s2 <= r_s1;
      r_prev <= r_s2;
      r_push <= 1'b0;
      r_cnt <= w_tick ? FULL : r_cnt - 1'b1;
      case (r_state)
        S_IDLE: if (r_prev && !r_s2) begin
          r_state <= S_START;
          r_cnt <= HALF;
        end
        S_START: if (w_tick) begin
          r_state <= r_s2 ? S_IDLE : S_DATA;
          r_bit <= '0;
          r_ferr <= 1'b0;
          r_perr <= 1'b0;
        end
        S_DATA: if (w_tick) begin
          r_shift <= {r_s2, r_shift[DATA_BITS-1:1]};
          r_bit <= r_bit == LAST_D ? 3'd0 : r_bit + 1'b1;
          if (r_bit == LAST_D) r_state <= PARITY != PAR_NONE ? S_PARITY : S_STOP;
        end
        S_PARITY: if (w_tick) begin
          r_perr <= (^r_shift ^ r_s2) == (PARITY == PAR_EVEN);
          r_state <= S_STOP;
        end
        S_STOP: if (w_tick) begin
          r_bit <= r_bit + 1'b1;
          if (!r_s2) r_ferr <= 1'b1;
          if (r_bit == LAST_S) begin
            r_push <= 1'b1;
            r_pdata <= {r_shift, r_ferr | !r_s2, r_perr};
            r_state <= r_s2 ? S_IDLE : S_BREAK;
          end
        end
        S_BREAK: if (r_s2) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  // frame counter saturates; overflow is sticky when a push meets a full FIFO without a pop
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
      r_ovf <= 1'b0;
    end else if (r_push) begin
      if (r_count != 16'hFFFF) r_count <= r_count + 16'd1;
      if (w_full && !w_pop) r_ovf <= 1'b1;
    end
  end
  rvfpga_sync_fifo #(.WIDTH(DATA_BITS + 2), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk(clk),
    .rst(rst),
    .i_wr(r_push),
    .i_wdata(r_pdata),
    .i_rd(w_pop),
    .o_rdata(w_head),
    .o_full(w_full),
    .o_empty(w_empty),
    .o_level(o_level)
  );
endmodule

// File: tb/tb_rvfpga_uart_monitor.sv
// tb_rvfpga_uart_monitor: randomized UART frames checked against a frame-level reference model
module tb_rvfpga_uart_monitor;
  logic clk = 1'b0;
  logic [3:0] rstv, rx, rdy, vld, fe, pe, ovf;
  logic [7:0] dat0, dat2, dat3;
  logic [6:0] dat1;
  logic [4:0] lvl0, lvl1, lvl2;
  logic [2:0] lvl3;
  logic [15:0] cnt0, cnt1, cnt2, cnt3;
  logic [9:0] got [4][$];
  logic [9:0] exp [4][$];
  int cnt_exp [4];
  bit ovf_exp [4];
  int errors = 0, checks = 0;

  always #5 clk = ~clk;

  rvfpga_uart_monitor #(.CLKS_PER_BIT(16)) u0 (.clk(clk), .rst(rstv[0]), .i_rx(rx[0]), .o_data(dat0),
    .o_frame_err(fe[0]), .o_parity_err(pe[0]), .o_valid(vld[0]), .i_ready(rdy[0]), .o_overflow(ovf[0]),
    .o_level(lvl0), .o_count(cnt0));
  rvfpga_uart_monitor #(.CLKS_PER_BIT(16), .DATA_BITS(7), .PARITY(2)) u1 (.clk(clk), .rst(rstv[1]), .i_rx(rx[1]),
    .o_data(dat1), .o_frame_err(fe[1]), .o_parity_err(pe[1]), .o_valid(vld[1]), .i_ready(rdy[1]),
    .o_overflow(ovf[1]), .o_level(lvl1), .o_count(cnt1));
  rvfpga_uart_monitor #(.CLKS_PER_BIT(16), .STOP_BITS(2)) u2 (.clk(clk), .rst(rstv[2]), .i_rx(rx[2]), .o_data(dat2),
    .o_frame_err(fe[2]), .o_parity_err(pe[2]), .o_valid(vld[2]), .i_ready(rdy[2]), .o_overflow(ovf[2]),
    .o_level(lvl2), .o_count(cnt2));
  rvfpga_uart_monitor #(.CLKS_PER_BIT(16), .FIFO_DEPTH(4)) u3 (.clk(clk), .rst(rstv[3]), .i_rx(rx[3]), .o_data(dat3),
    .o_frame_err(fe[3]), .o_parity_err(pe[3]), .o_valid(vld[3]), .i_ready(rdy[3]), .o_overflow(ovf[3]),
    .o_level(lvl3), .o_count(cnt3));

  function automatic logic [9:0] head(input int d);
    case (d)
      0: return {dat0, fe[0], pe[0]};
      1: return {1'b0, dat1, fe[1], pe[1]};
      2: return {dat2, fe[2], pe[2]};
      default: return {dat3, fe[3], pe[3]};
    endcase
  endfunction

  // every accepted pop is recorded at the falling edge preceding the popping edge
  always @(negedge clk) begin
    for (int d = 0; d < 4; d++) if (vld[d] && rdy[d]) got[d].push_back(head(d));
  end

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bitt(input int d, input logic b);
    rx[d] = b;
    wait_cyc(16);
  endtask

  // drives one frame and records what a correct receiver must deliver for it
  task automatic send(input int d, input logic [7:0] din, input bit flip, input bit [1:0] stops, input int gap);
    int nb, ns, depth;
    bit par, pb, ferr, perr;
    logic [7:0] v;
    nb = d == 1 ? 7 : 8;
    ns = d == 2 ? 2 : 1;
    par = d == 1;
    depth = d == 3 ? 4 : 16;
    v = d == 1 ? {1'b0, din[6:0]} : din;
    pb = ($countones(v) % 2 == 1) ^ flip;
    perr = par && (($countones(v) + int'(pb)) % 2 == 1);
    ferr = !stops[0] || (ns == 2 && !stops[1]);
    bitt(d, 1'b0);
    for (int i = 0; i < nb; i++) bitt(d, v[i]);
    if (par) bitt(d, pb);
    for (int i = 0; i < ns; i++) bitt(d, stops[i]);
    rx[d] = 1'b1;
    cnt_exp[d]++;
    if (!rdy[d] && exp[d].size() - got[d].size() >= depth) ovf_exp[d] = 1'b1;
    else exp[d].push_back({v, ferr, perr});
    if (gap > 0) wait_cyc(gap);
  endtask

  task automatic test_reset;
    if (vld !== 4'h0) begin errors++; $display("FAIL reset_valid got=%b want=0000", vld); end
    checks++;
    if (ovf !== 4'h0) begin errors++; $display("FAIL reset_overflow got=%b want=0000", ovf); end
    checks++;
    if ({fe, pe} !== 8'h0) begin errors++; $display("FAIL reset_flags got=%b want=0", {fe, pe}); end
    checks++;
    if ({cnt0, cnt1, cnt2, cnt3} !== 64'h0) begin errors++; $display("FAIL reset_count got=%h want=0", {cnt0, cnt1, cnt2, cnt3}); end
    checks++;
    if ({lvl0, lvl1, lvl2, lvl3, dat0} !== 26'h0) begin errors++; $display("FAIL reset_level_data got=%h want=0", {lvl0, lvl1, lvl2, lvl3, dat0}); end
    checks++;
  endtask

  task automatic test_8n1;
    send(0, 8'h55, 0, 2'b11, 0);
    send(0, 8'hA3, 0, 2'b11, 0);
    for (int i = 0; i < 6; i++) send(0, 8'($urandom), 0, 2'b11, $urandom_range(0, 20));
    wait_cyc(40);
    if (got[0].size() !== exp[0].size()) begin errors++; $display("FAIL 8n1_pops got=%0d want=%0d", got[0].size(), exp[0].size()); end
    checks++;
    for (int i = 0; i < exp[0].size() && i < got[0].size(); i++) begin
      if (got[0][i] !== exp[0][i]) begin errors++; $display("FAIL 8n1_char%0d got=%h want=%h", i, got[0][i], exp[0][i]); end
      checks++;
    end
    if (cnt0 !== 16'(cnt_exp[0])) begin errors++; $display("FAIL 8n1_count got=%0d want=%0d", cnt0, cnt_exp[0]); end
    checks++;
    got[0].delete();
    exp[0].delete();
  endtask

  task automatic test_parity;
    send(1, 8'h41, 0, 2'b11, 16);
    send(1, 8'h41, 1, 2'b11, 16);
    for (int i = 0; i < 6; i++) send(1, 8'($urandom), 1'($urandom), 2'b11, $urandom_range(0, 20));
    wait_cyc(40);
    if (got[1].size() !== exp[1].size()) begin errors++; $display("FAIL 7e1_pops got=%0d want=%0d", got[1].size(), exp[1].size()); end
    checks++;
    for (int i = 0; i < exp[1].size() && i < got[1].size(); i++) begin
      if (got[1][i] !== exp[1][i]) begin errors++; $display("FAIL 7e1_char%0d got=%h want=%h", i, got[1][i], exp[1][i]); end
      checks++;
    end
    if (cnt1 !== 16'(cnt_exp[1])) begin errors++; $display("FAIL 7e1_count got=%0d want=%0d", cnt1, cnt_exp[1]); end
    checks++;
    got[1].delete();
    exp[1].delete();
  endtask

  task automatic test_frame_break;
    send(2, 8'($urandom), 0, 2'b01, 32);
    send(2, 8'($urandom), 0, 2'b11, 0);
    wait_cyc(32);
    rx[2] = 1'b0;
    wait_cyc(40 * 16);
    if (cnt2 !== 16'(cnt_exp[2] + 1)) begin errors++; $display("FAIL break_count_low got=%0d want=%0d", cnt2, cnt_exp[2] + 1); end
    checks++;
    rx[2] = 1'b1;
    cnt_exp[2]++;
    exp[2].push_back({8'h00, 1'b1, 1'b0});
    wait_cyc(48);
    send(2, 8'($urandom), 0, 2'b11, 48);
    if (got[2].size() !== exp[2].size()) begin errors++; $display("FAIL 8n2_pops got=%0d want=%0d", got[2].size(), exp[2].size()); end
    checks++;
    for (int i = 0; i < exp[2].size() && i < got[2].size(); i++) begin
      if (got[2][i] !== exp[2][i]) begin errors++; $display("FAIL 8n2_char%0d got=%h want=%h", i, got[2][i], exp[2][i]); end
      checks++;
    end
    if (cnt2 !== 16'(cnt_exp[2])) begin errors++; $display("FAIL 8n2_count got=%0d want=%0d", cnt2, cnt_exp[2]); end
    checks++;
  endtask

  task automatic test_glitch;
    rx[0] = 1'b0;
    wait_cyc(6);
    rx[0] = 1'b1;
    wait_cyc(64);
    if (cnt0 !== 16'(cnt_exp[0])) begin errors++; $display("FAIL glitch_count got=%0d want=%0d", cnt0, cnt_exp[0]); end
    checks++;
    if (got[0].size() !== 0) begin errors++; $display("FAIL glitch_push got=%0d want=0", got[0].size()); end
    checks++;
  endtask

  task automatic test_overflow;
    rdy[3] = 1'b0;
    for (int i = 0; i < 5; i++) send(3, 8'($urandom), 0, 2'b11, 0);
    wait_cyc(16);
    if (int'(lvl3) !== exp[3].size()) begin errors++; $display("FAIL ovf_level got=%0d want=%0d", lvl3, exp[3].size()); end
    checks++;
    if (ovf[3] !== ovf_exp[3]) begin errors++; $display("FAIL ovf_flag got=%b want=%b", ovf[3], ovf_exp[3]); end
    checks++;
    if (cnt3 !== 16'(cnt_exp[3])) begin errors++; $display("FAIL ovf_count got=%0d want=%0d", cnt3, cnt_exp[3]); end
    checks++;
    rdy[3] = 1'b1;
    wait_cyc(10);
    rdy[3] = 1'b0;
    if (got[3].size() !== exp[3].size()) begin errors++; $display("FAIL drain_pops got=%0d want=%0d", got[3].size(), exp[3].size()); end
    checks++;
    for (int i = 0; i < exp[3].size() && i < got[3].size(); i++) begin
      if (got[3][i] !== exp[3][i]) begin errors++; $display("FAIL drain_char%0d got=%h want=%h", i, got[3][i], exp[3][i]); end
      checks++;
    end
    if (lvl3 !== 3'd0 || ovf[3] !== 1'b1) begin errors++; $display("FAIL drain_state level=%0d ovf=%b want 0/1", lvl3, ovf[3]); end
    checks++;
  endtask

  task automatic test_reset_mid;
    rdy[0] = 1'b0;
    send(0, 8'($urandom), 0, 2'b11, 16);
    if (vld[0] !== 1'b1) begin errors++; $display("FAIL pre_reset_valid got=%b want=1", vld[0]); end
    checks++;
    bitt(0, 1'b0);
    bitt(0, 1'b1);
    bitt(0, 1'b0);
    wait_cyc(8);
    rstv[0] = 1'b1;
    rx[0] = 1'b1;
    wait_cyc(1);
    rstv[0] = 1'b0;
    if ({vld[0], fe[0], pe[0], ovf[0], lvl0, cnt0, dat0} !== 33'h0) begin
      errors++; $display("FAIL mid_reset_outputs got=%h want=0", {vld[0], fe[0], pe[0], ovf[0], lvl0, cnt0, dat0});
    end
    checks++;
    got[0].delete();
    exp[0].delete();
    cnt_exp[0] = 0;
    rdy[0] = 1'b1;
    wait_cyc(32);
    send(0, 8'h7E, 0, 2'b11, 32);
    if (got[0].size() !== 1 || (got[0].size() > 0 && got[0][0] !== {8'h7E, 2'b00})) begin
      errors++; $display("FAIL post_reset_char n=%0d got=%h want=%h", got[0].size(), got[0].size() > 0 ? got[0][0] : 10'h0, {8'h7E, 2'b00});
    end
    checks++;
    if (cnt0 !== 16'd1) begin errors++; $display("FAIL post_reset_count got=%0d want=1", cnt0); end
    checks++;
  endtask

  initial begin
    rstv = 4'hF;
    rx = 4'hF;
    rdy = 4'hF;
    wait_cyc(3);
    rstv = 4'h0;
    test_reset;
    test_8n1;
    test_parity;
    test_frame_break;
    test_glitch;
    test_overflow;
    test_reset_mid;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
